// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer for the E stage: computes the HI/LO result at issue,
// holds busy for a fixed latency, then commits to the architectural HI/LO registers.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
  logic [31:0]        hi_nxt, lo_nxt;
  logic [63:0]        mul_q, div_q;

  function automatic logic [63:0] mul_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic        [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == OP_MULT) return sa * sb;
    return ua * ub;
  endfunction

  // Returns {remainder, quotient}; divide by zero returns the current {HI, LO} so commit is a no-op.
  function automatic logic [63:0] div_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
    logic signed [31:0] sa, sb;
    logic        [31:0] q, r;
    sa = a;
    sb = b;
    q  = 32'd0;
    r  = 32'd0;
    if (b == 32'd0) return {hi, lo};
    if (op == OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign mul_q = mul_res(mdOp, A, B);
  assign div_q = div_res(mdOp, A, B, HI, LO);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    hi_nxt      = HI;
    lo_nxt      = LO;
    if (state == RUN) begin
      if (flush) begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        pend_hi_nxt = 32'd0;
        pend_lo_nxt = 32'd0;
      end else if (cnt == CNT_W'(1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        hi_nxt    = pend_hi;
        lo_nxt    = pend_lo;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end else if (start && !flush) begin
      case (mdOp)
        OP_MULT, OP_MULTU: begin
          state_nxt   = RUN;
          cnt_nxt     = CNT_W'(MULT_CYCLES);
          pend_hi_nxt = mul_q[63:32];
          pend_lo_nxt = mul_q[31:0];
        end
        OP_DIV, OP_DIVU: begin
          state_nxt   = RUN;
          cnt_nxt     = CNT_W'(DIV_CYCLES);
          pend_hi_nxt = div_q[63:32];
          pend_lo_nxt = div_q[31:0];
        end
        OP_MTHI: hi_nxt = A;
        OP_MTLO: lo_nxt = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      HI      <= hi_nxt;
      LO      <= lo_nxt;
      busy    <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] A, B;
  logic        flush;
  logic        busy;
  logic [31:0] HI, LO;

  int tests = 0;
  int fails = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .resetN(resetN), .start(start), .mdOp(mdOp), .A(A), .B(B),
    .flush(flush), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles plus the result to commit.
  logic [31:0] m_hi = 0, m_lo = 0, m_ph = 0, m_pl = 0;
  int          m_left = 0;
  bit          armed = 0;

  function automatic void model_issue(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    longint      la, lb, ma, mb, q, r;
    logic [63:0] p;
    la = longint'(int'(a));
    lb = longint'(int'(b));
    case (op)
      3'd1: begin p = 64'(la * lb); m_ph = p[63:32]; m_pl = p[31:0]; m_left = 5; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; m_ph = p[63:32]; m_pl = p[31:0]; m_left = 5; end
      3'd3, 3'd4: begin
        m_left = 10;
        m_ph = m_hi;
        m_pl = m_lo;
        if (b != 0) begin
          if (op == 3'd4) begin
            m_pl = a / b;
            m_ph = a % b;
          end else begin
            ma = (la < 0) ? -la : la;
            mb = (lb < 0) ? -lb : lb;
            q = ma / mb;
            r = ma % mb;
            if ((la < 0) != (lb < 0)) q = -q;
            if (la < 0) r = -r;
            m_pl = q[31:0];
            m_ph = r[31:0];
          end
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!resetN) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      if (flush) m_left = 0;
      else if (m_left == 1) begin m_hi = m_ph; m_lo = m_pl; m_left = 0; end
      else m_left--;
    end else if (start && !flush) begin
      model_issue(mdOp, A, B);
    end
    armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_busy", {31'b0, busy}, {31'b0, m_left > 0});
      chk("model_hi", HI, m_hi);
      chk("model_lo", LO, m_lo);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdOp = op; A = a; B = b;
    cyc(1);
    start = 1'b0; mdOp = 3'd0;
  endtask

  task automatic count_busy(input string nm, input int exp_n);
    int n = 0;
    while (busy && n < 64) begin
      n++;
      cyc(1);
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    issue(op, a, b);
    count_busy({nm, "_cycles"}, exp_n);
    chk({nm, "_hi"}, HI, exp_hi);
    chk({nm, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    resetN = 1'b0; start = 1'b1; mdOp = 3'd1; A = 32'd3; B = 32'd4; flush = 1'b0;
    cyc(2);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    resetN = 1'b1; start = 1'b0; mdOp = 3'd0;
    cyc(1);

    run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    issue(3'd5, 32'h1234, 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    issue(3'd6, 32'h5678, 32'd0);
    chk("mtlo_lo", LO, 32'h5678);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    run_op("divu_zero", 3'd4, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);

    // Flush in busy cycle 3, then on the commit cycle.
    issue(3'd1, 32'd3, 32'd5);
    cyc(2);
    flush = 1'b1; cyc(1); flush = 1'b0;
    chk("flush3_busy", {31'b0, busy}, 32'd0);
    chk("flush3_lo", LO, 32'h5678);
    issue(3'd1, 32'd3, 32'd5);
    cyc(4);
    flush = 1'b1; cyc(1); flush = 1'b0;
    chk("flush5_busy", {31'b0, busy}, 32'd0);
    chk("flush5_hi", HI, 32'h1234);
    chk("flush5_lo", LO, 32'h5678);
    cyc(8);
    chk("flush5_late_lo", LO, 32'h5678);

    flush = 1'b1;
    issue(3'd6, 32'hDEAD, 32'd0);
    flush = 1'b0;
    chk("flush_mtlo_lo", LO, 32'h5678);

    issue(3'd1, 32'd2, 32'd2);
    cyc(1);
    issue(3'd1, 32'd3, 32'd4);
    count_busy("ignored_cycles", 3);
    chk("ignored_lo", LO, 32'd4);
    chk("ignored_hi", HI, 32'd0);

    run_op("b2b_mult", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);
    run_op("b2b_multu", 3'd2, 32'h8000_0000, 32'd4, 5, 32'd2, 32'd0);

    issue(3'd3, 32'd100, 32'd7);
    cyc(3);
    resetN = 1'b0; cyc(1); resetN = 1'b1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    cyc(12);
    chk("midrst_late_hi", HI, 32'd0);
    chk("midrst_late_lo", LO, 32'd0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multi-cycle multiply/divide sequencer for the E stage, sitting beside the single-cycle ALU. It accepts one HI/LO operation per start pulse and computes the full result at issue. It then holds `busy` for a fixed parameterised latency before committing the result to the architectural HI/LO registers. The E-stage stall logic uses `start | busy`. The exception path uses `flush` to abandon an in-flight operation.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

- `clk`  in  1: sole clock; all state updates on rising edge.
- `resetN`  in  1: reset is synchronous and active-low.
- `start`  in  1: issue strobe, sampled on rising edge.
- `mdOp`  in  3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none.
- `A`  in  32: rs operand (dividend / multiplicand / mthi/mtlo source).
- `B`  in  32: rt operand (divisor / multiplier).
- `flush`  in  1: abandon the in-flight op.
- `busy`  out  1: registered; high while an op is pending.
- `HI`  out  32: architectural HI, registered.
- `LO`  out  32: architectural LO, registered.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter `cnt` active.
- Reset (`resetN`=0 at an edge): state IDLE, `cnt`=0, HI=LO=0, pending result regs=0. Reset overrides `start` and `flush`.
- IDLE, `start`=1, mdOp ∈ {1..4}, `flush`=0:
  - compute result from A/B combinationally and latch it into pendHI/pendLO;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES; go to RUN.
- Multiply results:
  - mult: {HI,LO} = signed 64-bit A×B.
  - multu: {HI,LO} = unsigned 64-bit A×B.
- Divide results:
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of A.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: LO = A/B, HI = A%B, both unsigned.
  - Divide by zero (B=0, div or divu): still runs DIV_CYCLES with busy=1; HI/LO unchanged at commit.
- IDLE, `start`=1, mdOp=5 (mthi): HI←A on that edge; mdOp=6 (mtlo): LO←A. No busy; state stays IDLE.
- IDLE, `start`=1, mdOp ∈ {0,7}: no effect.
- RUN: `cnt` decrements each edge. On the edge where `cnt`=1: HI←pendHI, LO←pendLO, state→IDLE.
- `start` while busy=1: ignored entirely; upstream guarantees this does not happen in normal flow.
- `flush`=1 in RUN: next edge goes to IDLE, `cnt`=0, HI/LO unchanged, pending result discarded. This holds even if `cnt`=1 on that edge: flush wins over commit.
- `flush`=1 with `start`=1 in IDLE: `start` ignored, including mthi/mtlo.
- mfhi/mflo are not ops here. Readers take HI/LO directly and must stall while `start | busy`.

## Timing
- Start sampled at edge ending cycle t:
  - busy=1 in cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES);
  - new HI/LO visible and busy=0 from cycle t+N+1.
- Back-to-back: a new `start` is accepted in cycle t+N+1. There is no bubble between ops.
- mthi/mtlo: value visible in cycle t+1. Zero busy cycles.
- HI, LO and busy are pure register outputs with no combinational path from inputs.
- Operands are latched at issue. A/B changing during RUN has no effect.

## Test plan
- Reset check: hold resetN=0 for 2 edges with start=1, mdOp=1 → busy=0, HI=LO=0. Release, then mult A=0xFFFFFFFF, B=2 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide: div A=0xFFFFFFF9 (−7), B=2 → busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: mthi 0x1234, mtlo 0x5678 (each visible the next cycle, busy stays 0), then divu B=0 → busy 10 cycles, HI=0x1234 and LO=0x5678 unchanged.
- Flush: flush at busy cycle 3, and separately at busy cycle 5 (the commit edge) → busy=0 the next cycle, HI/LO keep their old values. start+flush together in IDLE with mtlo → LO unchanged.
- Ignored start: start with mult 3×4 while busy from a prior mult 2×2 → final LO=4, busy falls on schedule. Back-to-back: mult then multu issued in cycle t+6 → second result commits at t+11.
- Mid-operation reset: resetN=0 during RUN → next cycle busy=0, HI=LO=0, no later commit.
